ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. Sends one command byte to the mouse, for example 0xF4 "enable data reporting", 0xFF "reset" or 0xF3 "set sample rate".
- Opposite direction of the mouse receive path: it generates the request-to-send sequence, shifts out data, parity and stop bits on device-generated clock edges, and checks the device ACK.
- Sits in the 100 MHz mouse clock domain, beside the mouse controller, on the shared open-drain ps2_clk/ps2_data pins.
- Exports busy so the receive path ignores bus activity while a transmission is in progress.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_line_sync.sv | 38 +++
 rtl/ps2_host_tx.sv | 213 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared state type, error codes and timing helper for the PS/2 host path
package ps2_pkg;

   localparam int CNT_W = 21;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      WAIT_FIRST,
      SHIFT,
      WAIT_ACK,
      WAIT_IDLE
   } ps2_tx_state_e;

   localparam logic [1:0] ERR_NONE   = 2'b00;
   localparam logic [1:0] ERR_NO_CLK = 2'b01;
   localparam logic [1:0] ERR_FRAME  = 2'b10;
   localparam logic [1:0] ERR_NO_ACK = 2'b11;

   // 64-bit product so 15 ms at 100 MHz does not overflow before the divide.
   function automatic int unsigned us_to_cycles(input int unsigned us, input int unsigned freq);
      logic [63:0] prod;
      prod = (64'(us) * 64'(freq)) / 64'd1_000_000;
      return prod[31:0];
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-FF synchronizer and falling-edge detect for the PS/2 clock and data pins
module ps2_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk_i,
   input  logic ps2_data_i,
   output logic clk_s_o,
   output logic data_s_o,
   output logic clk_fe_o,
   output logic data_fe_o
);

   logic [1:0] clk_sync_q;
   logic [1:0] data_sync_q;
   logic       clk_prev_q;
   logic       data_prev_q;

   // Idle bus level is high, so reset to 1 to avoid a false edge after reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         clk_prev_q  <= 1'b1;
         data_prev_q <= 1'b1;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
         data_sync_q <= {data_sync_q[0], ps2_data_i};
         clk_prev_q  <= clk_sync_q[1];
         data_prev_q <= data_sync_q[1];
      end
   end

   assign clk_s_o   = clk_sync_q[1];
   assign data_s_o  = data_sync_q[1];
   assign clk_fe_o  = clk_prev_q & ~clk_sync_q[1];
   assign data_fe_o = data_prev_q & ~data_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter with request-to-send, shift-out and ACK check
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ           = 100_000_000,
   parameter int unsigned INHIBIT_US            = 100,
   parameter int unsigned FIRST_EDGE_TIMEOUT_US = 15000,
   parameter int unsigned FRAME_TIMEOUT_US      = 2000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam logic [CNT_W-1:0] INHIBIT_LOAD =
      CNT_W'(us_to_cycles(INHIBIT_US, CLK_FREQ_HZ) - 1);
   localparam logic [CNT_W-1:0] FIRST_LOAD =
      CNT_W'(us_to_cycles(FIRST_EDGE_TIMEOUT_US, CLK_FREQ_HZ) - 1);
   localparam logic [CNT_W-1:0] FRAME_LOAD =
      CNT_W'(us_to_cycles(FRAME_TIMEOUT_US, CLK_FREQ_HZ) - 1);

   ps2_tx_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [8:0]       shift_q, shift_d;
   logic             clk_oe_q, clk_oe_d;
   logic             data_oe_q, data_oe_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [1:0]       err_code_q, err_code_d;
   logic             tx_ready_q, tx_ready_d;

   logic             clk_s, data_s, clk_fe, data_fe_unused;
   logic             timeout;
   logic             fail;
   logic [1:0]       fail_code;
   logic [CNT_W-1:0] cnt_dec;

   ps2_line_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk_i (ps2_clk_in),
      .ps2_data_i(ps2_data_in),
      .clk_s_o   (clk_s),
      .data_s_o  (data_s),
      .clk_fe_o  (clk_fe),
      .data_fe_o (data_fe_unused)
   );

   assign timeout = (cnt_q == '0);
   assign cnt_dec = cnt_q - CNT_W'(1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         clk_oe_q   <= 1'b0;
         data_oe_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
         tx_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         clk_oe_q   <= clk_oe_d;
         data_oe_q  <= data_oe_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         tx_ready_q <= tx_ready_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      clk_oe_d   = clk_oe_q;
      data_oe_d  = data_oe_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_code_d = err_code_q;
      fail       = 1'b0;
      fail_code  = ERR_NONE;

      case (state_q)
         IDLE: begin
            if (tx_valid && tx_ready_q) begin
               state_d    = INHIBIT;
               shift_d    = {~^tx_data, tx_data};
               err_code_d = ERR_NONE;
               clk_oe_d   = 1'b1;
               cnt_d      = INHIBIT_LOAD;
            end
         end
         // Clock is held low for INHIBIT_US in total; the REQ cycle is the last of them.
         INHIBIT: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_d   = REQ;
               data_oe_d = 1'b1;
            end else begin
               cnt_d = cnt_dec;
            end
         end
         REQ: begin
            state_d  = WAIT_FIRST;
            clk_oe_d = 1'b0;
            cnt_d    = FIRST_LOAD;
         end
         WAIT_FIRST: begin
            if (timeout) begin
               fail      = 1'b1;
               fail_code = ERR_NO_CLK;
            end else if (clk_fe) begin
               state_d   = SHIFT;
               data_oe_d = ~shift_q[0];
               shift_d   = {1'b0, shift_q[8:1]};
               bit_cnt_d = '0;
               cnt_d     = FRAME_LOAD;
            end else begin
               cnt_d = cnt_dec;
            end
         end
         // Data bit 0 already went out on the edge that left WAIT_FIRST.
         SHIFT: begin
            if (timeout) begin
               fail      = 1'b1;
               fail_code = ERR_FRAME;
            end else begin
               cnt_d = cnt_dec;
               if (clk_fe) begin
                  if (bit_cnt_q == 4'd8) begin
                     state_d   = WAIT_ACK;
                     data_oe_d = 1'b0;
                  end else begin
                     data_oe_d = ~shift_q[0];
                     shift_d   = {1'b0, shift_q[8:1]};
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
         end
         WAIT_ACK: begin
            if (timeout) begin
               fail      = 1'b1;
               fail_code = ERR_FRAME;
            end else begin
               cnt_d = cnt_dec;
               if (clk_fe) begin
                  if (!data_s) begin
                     state_d = WAIT_IDLE;
                  end else begin
                     fail      = 1'b1;
                     fail_code = ERR_NO_ACK;
                  end
               end
            end
         end
         WAIT_IDLE: begin
            if (timeout) begin
               fail      = 1'b1;
               fail_code = ERR_FRAME;
            end else begin
               cnt_d = cnt_dec;
               if (clk_s && data_s) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (fail) begin
         state_d    = IDLE;
         clk_oe_d   = 1'b0;
         data_oe_d  = 1'b0;
         err_d      = 1'b1;
         err_code_d = fail_code;
      end

      busy_d     = (state_d != IDLE);
      tx_ready_d = (state_d == IDLE) && !done_d && !err_d;
   end

   assign tx_ready    = tx_ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign err_code    = err_code_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with an open-drain PS/2 device model
module tb_ps2_host_tx;

   logic       clk;
   logic       rst;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready, busy, done, err;
   logic [1:0] err_code;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       dev_clk, dev_data;
   logic       pin_clk, pin_data;

   int pass_cnt  = 0;
   int check_cnt = 0;
   int cyc       = 0;
   int done_cnt  = 0;
   int err_cnt   = 0;
   int both_cnt  = 0;
   int err_cyc   = 0;
   logic [1:0] last_code = 2'b00;
   int t_first_fe;
   logic exp_bits[$];

   // Wired-AND open-drain bus: either side can pull a line low.
   assign pin_clk  = dev_clk & ~ps2_clk_oe;
   assign pin_data = dev_data & ~ps2_data_oe;

   ps2_host_tx #(
      .CLK_FREQ_HZ          (1_000_000),
      .INHIBIT_US           (100),
      .FIRST_EDGE_TIMEOUT_US(15000),
      .FRAME_TIMEOUT_US     (2000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .err_code   (err_code),
      .ps2_clk_in (pin_clk),
      .ps2_data_in(pin_data),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (err) begin
         err_cnt   <= err_cnt + 1;
         last_code <= err_code;
         err_cyc   <= cyc;
      end
      if (done && err) both_cnt <= both_cnt + 1;
   end

   task automatic send_byte(input logic [7:0] b, output int low_cyc);
      int guard;
      guard = 0;
      while (!tx_ready && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      tx_valid = 1'b1;
      tx_data  = b;
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
      exp_bits.push_back(($countones(b) % 2) == 0);
      exp_bits.push_back(1'b1);
      @(negedge clk);
      tx_valid = 1'b0;
      low_cyc  = 0;
      while (ps2_clk_oe && low_cyc < 1000) begin
         low_cyc++;
         @(negedge clk);
      end
   endtask

   // Device model: 80-cycle clock period, samples data just before each rising edge.
   task automatic dev_frame(input int n_clk, input bit ack_low);
      logic e;
      repeat (30) @(negedge clk);
      for (int k = -1; k < n_clk; k++) begin
         if (k >= 0) begin
            dev_clk = 1'b0;
            if (k == 0) t_first_fe = cyc;
            repeat (40) @(negedge clk);
         end
         check_cnt++;
         if (exp_bits.size() == 0) begin
            $display("FAIL frame_bit%0d got %0b required a queued bit", k + 1, pin_data);
         end else begin
            e = exp_bits.pop_front();
            if (pin_data !== e)
               $display("FAIL frame_bit%0d got %0b required %0b", k + 1, pin_data, e);
            else
               pass_cnt++;
         end
         if (k >= 0) begin
            dev_clk = 1'b1;
            repeat (40) @(negedge clk);
         end
      end
      if (n_clk == 10) begin
         dev_data = ack_low ? 1'b0 : 1'b1;
         repeat (20) @(negedge clk);
         dev_clk = 1'b0;
         repeat (40) @(negedge clk);
         dev_clk = 1'b1;
         repeat (20) @(negedge clk);
         dev_data = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst      = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      repeat (3) @(negedge clk);
      check_cnt++; if (ps2_clk_oe !== 1'b0) $display("FAIL rst_clk_oe got %0b required 0", ps2_clk_oe); else pass_cnt++;
      check_cnt++; if (ps2_data_oe !== 1'b0) $display("FAIL rst_data_oe got %0b required 0", ps2_data_oe); else pass_cnt++;
      check_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b required 0", busy); else pass_cnt++;
      check_cnt++; if (done !== 1'b0) $display("FAIL rst_done got %0b required 0", done); else pass_cnt++;
      check_cnt++; if (err !== 1'b0) $display("FAIL rst_err got %0b required 0", err); else pass_cnt++;
      check_cnt++; if (err_code !== 2'b00) $display("FAIL rst_err_code got %0b required 00", err_code); else pass_cnt++;
      check_cnt++; if (tx_ready !== 1'b1) $display("FAIL rst_tx_ready got %0b required 1", tx_ready); else pass_cnt++;
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_send(input logic [7:0] b);
      int low, n, d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      send_byte(b, low);
      check_cnt++; if (low !== 100) $display("FAIL inhibit_len_%h got %0d required 100", b, low); else pass_cnt++;
      check_cnt++; if (ps2_data_oe !== 1'b1) $display("FAIL start_hold_%h got %0b required 1", b, ps2_data_oe); else pass_cnt++;
      check_cnt++; if (busy !== 1'b1) $display("FAIL busy_%h got %0b required 1", b, busy); else pass_cnt++;
      dev_frame(10, 1'b1);
      n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_cnt++; if (done !== 1'b1) $display("FAIL done_seen_%h got %0b required 1", b, done); else pass_cnt++;
      check_cnt++; if (tx_ready !== 1'b0) $display("FAIL ready_at_done_%h got %0b required 0", b, tx_ready); else pass_cnt++;
      @(negedge clk);
      check_cnt++; if (tx_ready !== 1'b1) $display("FAIL ready_after_done_%h got %0b required 1", b, tx_ready); else pass_cnt++;
      check_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy_%h got %0b required 0", b, busy); else pass_cnt++;
      check_cnt++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL idle_oe_%h got %b required 00", b, {ps2_clk_oe, ps2_data_oe}); else pass_cnt++;
      check_cnt++; if (done_cnt - d0 !== 1) $display("FAIL done_count_%h got %0d required 1", b, done_cnt - d0); else pass_cnt++;
      check_cnt++; if (err_cnt - e0 !== 0) $display("FAIL err_count_%h got %0d required 0", b, err_cnt - e0); else pass_cnt++;
      check_cnt++; if (exp_bits.size() !== 0) $display("FAIL bits_left_%h got %0d required 0", b, exp_bits.size()); else pass_cnt++;
   endtask

   task automatic test_no_clock();
      int low, n;
      send_byte(8'h55, low);
      exp_bits.delete();
      n = 0;
      while (!err && n < 16000) begin
         @(negedge clk);
         n++;
      end
      check_cnt++; if (n !== 15000) $display("FAIL first_edge_timeout got %0d cycles required 15000", n); else pass_cnt++;
      check_cnt++; if (err_code !== 2'b01) $display("FAIL no_clk_code got %b required 01", err_code); else pass_cnt++;
      check_cnt++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL no_clk_oe got %b required 00", {ps2_clk_oe, ps2_data_oe}); else pass_cnt++;
      check_cnt++; if (busy !== 1'b0) $display("FAIL no_clk_busy got %0b required 0", busy); else pass_cnt++;
      check_cnt++; if (done !== 1'b0) $display("FAIL no_clk_done got %0b required 0", done); else pass_cnt++;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_no_ack();
      int low, d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      send_byte(8'hA5, low);
      dev_frame(10, 1'b0);
      repeat (10) @(negedge clk);
      check_cnt++; if (err_cnt - e0 !== 1) $display("FAIL no_ack_err_count got %0d required 1", err_cnt - e0); else pass_cnt++;
      check_cnt++; if (last_code !== 2'b11) $display("FAIL no_ack_code got %b required 11", last_code); else pass_cnt++;
      check_cnt++; if (done_cnt - d0 !== 0) $display("FAIL no_ack_done got %0d required 0", done_cnt - d0); else pass_cnt++;
      check_cnt++; if (tx_ready !== 1'b1) $display("FAIL no_ack_ready got %0b required 1", tx_ready); else pass_cnt++;
      exp_bits.delete();
   endtask

   task automatic test_frame_timeout();
      int low, n, e0, delta;
      e0 = err_cnt;
      send_byte(8'h3C, low);
      dev_frame(4, 1'b1);
      n = 0;
      while (err_cnt == e0 && n < 2500) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      delta = err_cyc - t_first_fe;
      check_cnt++; if (err_cnt - e0 !== 1) $display("FAIL frame_err_count got %0d required 1", err_cnt - e0); else pass_cnt++;
      check_cnt++; if (last_code !== 2'b10) $display("FAIL frame_code got %b required 10", last_code); else pass_cnt++;
      check_cnt++; if (!(delta >= 1995 && delta <= 2005)) $display("FAIL frame_timeout got %0d cycles required 1995..2005", delta); else pass_cnt++;
      check_cnt++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL frame_oe got %b required 00", {ps2_clk_oe, ps2_data_oe}); else pass_cnt++;
      exp_bits.delete();
   endtask

   task automatic test_reset_mid();
      int low, d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      send_byte(8'h86, low);
      dev_frame(4, 1'b1);
      dev_clk = 1'b0;
      repeat (10) @(negedge clk);
      check_cnt++; if (ps2_data_oe !== 1'b1) $display("FAIL mid_bit4 got %0b required 1", ps2_data_oe); else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
      check_cnt++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL mid_rst_oe got %b required 00", {ps2_clk_oe, ps2_data_oe}); else pass_cnt++;
      check_cnt++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %0b required 0", busy); else pass_cnt++;
      check_cnt++; if (tx_ready !== 1'b1) $display("FAIL mid_rst_ready got %0b required 1", tx_ready); else pass_cnt++;
      check_cnt++; if ({done, err} !== 2'b00) $display("FAIL mid_rst_pulse got %b required 00", {done, err}); else pass_cnt++;
      rst     = 1'b1;
      dev_clk = 1'b1;
      repeat (50) @(negedge clk);
      check_cnt++; if (done_cnt - d0 !== 0) $display("FAIL mid_rst_done got %0d required 0", done_cnt - d0); else pass_cnt++;
      check_cnt++; if (err_cnt - e0 !== 0) $display("FAIL mid_rst_err got %0d required 0", err_cnt - e0); else pass_cnt++;
      exp_bits.delete();
   endtask

   task automatic test_back_to_back();
      int low, n, d0;
      d0 = done_cnt;
      send_byte(8'h12, low);
      tx_valid = 1'b1;
      tx_data  = 8'h34;
      @(negedge clk);
      tx_valid = 1'b0;
      check_cnt++; if (busy !== 1'b1) $display("FAIL stray_busy got %0b required 1", busy); else pass_cnt++;
      check_cnt++; if (tx_ready !== 1'b0) $display("FAIL stray_ready got %0b required 0", tx_ready); else pass_cnt++;
      dev_frame(10, 1'b1);
      n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check_cnt++; if (tx_ready !== 1'b1) $display("FAIL b2b_ready got %0b required 1", tx_ready); else pass_cnt++;
      send_byte(8'hF3, low);
      check_cnt++; if (low !== 100) $display("FAIL b2b_inhibit got %0d required 100", low); else pass_cnt++;
      dev_frame(10, 1'b1);
      repeat (20) @(negedge clk);
      check_cnt++; if (done_cnt - d0 !== 2) $display("FAIL b2b_done_count got %0d required 2", done_cnt - d0); else pass_cnt++;
      check_cnt++; if (exp_bits.size() !== 0) $display("FAIL b2b_bits_left got %0d required 0", exp_bits.size()); else pass_cnt++;
      check_cnt++; if (both_cnt !== 0) $display("FAIL done_err_overlap got %0d required 0", both_cnt); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_send(8'hF4);
      test_send(8'h00);
      test_send(8'hFF);
      test_no_clock();
      test_no_ack();
      test_frame_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
